// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Packs decoded MIPS instruction fields into 32-bit words, buffers them in a
// small FIFO and writes them one by one into instruction memory starting at
// BASE_ADDR. Used as a program loader before the CPU leaves reset.
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   start             begin a load session (honoured only in IDLE)
//   in_valid/in_ready field-bundle handshake; in_last marks the final bundle
//   fmt               00 R-type, 01 I-type, 10 J-type, 11 illegal
//   op..target        instruction fields
//   mem_we/addr/wdata write request to instruction memory, held until mem_ack
//   mem_ack           memory accepted the write this cycle
//   busy, done        not-IDLE flag, one-cycle end-of-session pulse
//   count             words written in the current or last session
//   err_fmt, err_wrap sticky illegal-format / address-wrap flags
//   dbg_state         FSM state: 0 IDLE, 1 LOAD, 2 DRAIN, 3 DONE
//
// Handshakes: a bundle transfers on a rising edge where in_valid && in_ready;
// a memory write completes on a rising edge where mem_we && mem_ack. mem_we,
// mem_addr and mem_wdata stay stable while a write is pending.
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        fmt,
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        func,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_fmt,
    output logic              err_wrap,
    output logic [1:0]        dbg_state
);

    localparam int unsigned       PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
    localparam logic [PTR_W:0]    FULL_LVL = FIFO_DEPTH[PTR_W:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fifo_q [FIFO_DEPTH];
    logic [31:0]        fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     level_q, level_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               err_fmt_q, err_fmt_d;
    logic               err_wrap_q, err_wrap_d;

    logic [31:0]        enc_word;
    logic               fifo_empty, fifo_full;
    logic               accept, push, pop, ack, active;

    // Field packing; unused fields of each format are simply not selected.
    always_comb begin
        enc_word = '0;
        case (fmt)
            2'b00:   enc_word = {op, rs, rt, rd, shamt, func};
            2'b01:   enc_word = {op, rs, rt, imm};
            2'b10:   enc_word = {op, target};
            default: enc_word = '0;
        endcase
    end

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LVL);
    assign active     = (state_q == S_LOAD) || (state_q == S_DRAIN);
    // Readiness depends only on registered state, so a pop in the same cycle
    // never frees a slot for a push.
    assign in_ready   = (state_q == S_LOAD) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && (fmt != 2'b11);
    assign ack        = mem_we_q && mem_ack;
    // Pop when the write slot is free or is being freed this cycle, which
    // gives back-to-back writes when mem_ack is held high.
    assign pop        = active && !fifo_empty && (!mem_we_q || mem_ack);

    always_comb begin
        state_d     = state_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;
        err_fmt_d   = err_fmt_q;
        err_wrap_d  = err_wrap_q;

        if (push) begin
            fifo_d[wr_ptr_q] = enc_word;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (accept && (fmt == 2'b11)) begin
            err_fmt_d = 1'b1;
        end

        if (ack) begin
            mem_we_d   = 1'b0;
            mem_addr_d = mem_addr_q + 1'b1;
            count_d    = count_q + 1'b1;
            if (mem_addr_q == '1) begin
                err_wrap_d = 1'b1;
            end
        end
        // A pop issues the next write at the (possibly just advanced) address.
        if (pop) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = fifo_q[rd_ptr_q];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    mem_addr_d = BASE;
                    count_d    = '0;
                    err_fmt_d  = 1'b0;
                    err_wrap_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept && in_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty && !mem_we_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE;
            mem_wdata_q <= '0;
            count_q     <= '0;
            err_fmt_q   <= 1'b0;
            err_wrap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
            err_fmt_q   <= err_fmt_d;
            err_wrap_q  <= err_wrap_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign count     = count_q;
    assign err_fmt   = err_fmt_q;
    assign err_wrap  = err_wrap_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Two loader instances share every input: one with default parameters and one
// with ADDR_W=2, BASE_ADDR=3 so address wrap-around is observed on every
// session. Expected words come from a vector table and from an arithmetic
// field-packing model; expected addresses are base + write index.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  func;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
        logic [31:0] exp_word;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [1:0]  fmt = '0;
    logic [5:0]  op = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  func = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        mem_ack = 1'b0;

    logic        in_ready, mem_we, busy, done, err_fmt, err_wrap;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  count;
    logic [1:0]  dbg_state;

    logic        in_ready_b, mem_we_b, busy_b, done_b, err_fmt_b, err_wrap_b;
    logic [1:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [2:0]  count_b;
    logic [1:0]  dbg_state_b;

    instr_encoder_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .fmt(fmt), .op(op), .rs(rs),
        .rt(rt), .rd(rd), .shamt(shamt), .func(func), .imm(imm),
        .target(target), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy), .done(done),
        .count(count), .err_fmt(err_fmt), .err_wrap(err_wrap),
        .dbg_state(dbg_state)
    );

    instr_encoder_loader #(.ADDR_W(2), .FIFO_DEPTH(4), .BASE_ADDR(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_last(in_last), .fmt(fmt), .op(op), .rs(rs),
        .rt(rt), .rd(rd), .shamt(shamt), .func(func), .imm(imm),
        .target(target), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_ack(mem_ack), .busy(busy_b),
        .done(done_b), .count(count_b), .err_fmt(err_fmt_b),
        .err_wrap(err_wrap_b), .dbg_state(dbg_state_b)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[9];
    vec_t sess_q[$];
    int   ack_mode = 0;   // 0 tied high, 1 random, 2 low for 20 cycles then high
    bit   gap_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_word(input vec_t v);
        longint w;
        case (v.fmt)
            2'd0: w = longint'(v.op) * 2**26 + longint'(v.rs) * 2**21 + longint'(v.rt) * 2**16
                    + longint'(v.rd) * 2**11 + longint'(v.shamt) * 2**6 + longint'(v.func);
            2'd1: w = longint'(v.op) * 2**26 + longint'(v.rs) * 2**21 + longint'(v.rt) * 2**16
                    + longint'(v.imm);
            2'd2: w = longint'(v.op) * 2**26 + longint'(v.target);
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    function automatic vec_t mk(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                                input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                                input logic [5:0] fn, input logic [15:0] im,
                                input logic [25:0] tg, input logic l, input logic [31:0] e);
        vec_t v;
        v.fmt = f; v.op = o; v.rs = s; v.rt = t; v.rd = d; v.shamt = sh;
        v.func = fn; v.imm = im; v.target = tg; v.last = l; v.exp_word = e;
        return v;
    endfunction

    function automatic vec_t rand_vec(input bit allow_illegal, input bit l);
        vec_t v;
        if (allow_illegal && $urandom_range(0, 7) == 0) v.fmt = 2'b11;
        else v.fmt = 2'($urandom_range(0, 2));
        v.op = 6'($urandom); v.rs = 5'($urandom); v.rt = 5'($urandom);
        v.rd = 5'($urandom); v.shamt = 5'($urandom); v.func = 6'($urandom);
        v.imm = 16'($urandom); v.target = 26'($urandom); v.last = l;
        v.exp_word = model_word(v);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_fields(input vec_t v);
        fmt = v.fmt; op = v.op; rs = v.rs; rt = v.rt; rd = v.rd;
        shamt = v.shamt; func = v.func; imm = v.imm; target = v.target;
        in_last = v.last;
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        set_fields(v);
        in_valid = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        #1 in_valid = 1'b0;
        in_last = 1'b0;
        if (!ok) fail_now("send_accept");
    endtask

    // Runs one session from sess_q: drives bundles while a monitor drives
    // mem_ack, checks each completed write and the end-of-session status.
    task automatic run_session(input bit expect_block);
        logic [31:0] exp_q[$];
        logic [31:0] w, pd;
        logic [7:0]  pa;
        int          n_exp, n_wr, cyc;
        bit          exp_ferr, fin, prev_pend, saw_block;
        exp_ferr = 1'b0;
        foreach (sess_q[i]) begin
            if (sess_q[i].fmt == 2'b11) exp_ferr = 1'b1;
            else exp_q.push_back(sess_q[i].exp_word);
        end
        n_exp = exp_q.size();
        n_wr = 0; cyc = 0; fin = 1'b0; prev_pend = 1'b0; saw_block = 1'b0;
        pa = '0; pd = '0;
        start_pulse();
        fork
            begin
                foreach (sess_q[i]) begin
                    send(sess_q[i]);
                    if (gap_en && $urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 2)) @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                while (!fin && cyc < 800) begin
                    @(negedge clk);
                    cyc++;
                    if (prev_pend) begin
                        chk("hold_we", mem_we, 1);
                        chk("hold_addr", mem_addr, pa);
                        chk("hold_data", mem_wdata, pd);
                    end
                    case (ack_mode)
                        0:       mem_ack = 1'b1;
                        1:       mem_ack = 1'($urandom_range(0, 1));
                        default: mem_ack = (cyc > 20);
                    endcase
                    if (in_valid && !in_ready) saw_block = 1'b1;
                    if (mem_we && mem_ack) begin
                        if (exp_q.size() == 0) begin
                            chk("extra_write", mem_wdata, 0);
                            errors += (mem_wdata == 0) ? 1 : 0;
                        end else begin
                            w = exp_q.pop_front();
                            chk("wr_data", mem_wdata, w);
                            chk("wr_addr", mem_addr, 64'(n_wr % 256));
                            chk("wr_we_b", mem_we_b, 1);
                            chk("wr_data_b", mem_wdata_b, w);
                            chk("wr_addr_b", mem_addr_b, 64'((3 + n_wr) % 4));
                        end
                        n_wr++;
                    end
                    prev_pend = mem_we && !mem_ack;
                    pa = mem_addr;
                    pd = mem_wdata;
                    if (done) begin
                        fin = 1'b1;
                        chk("done_count", count, 64'(n_exp));
                        chk("done_count_b", count_b, 64'(n_exp));
                        chk("done_err_fmt", err_fmt, exp_ferr);
                        chk("done_err_fmt_b", err_fmt_b, exp_ferr);
                        chk("done_err_wrap", err_wrap, 0);
                        chk("done_err_wrap_b", err_wrap_b, (n_exp >= 1) ? 1 : 0);
                        chk("done_busy", busy, 1);
                        chk("done_b", done_b, 1);
                        chk("done_state", dbg_state, 3);
                        chk("done_state_b", dbg_state_b, 3);
                    end
                end
                if (!fin) fail_now("session_done");
            end
        join
        chk("writes_left", exp_q.size(), 0);
        if (expect_block) chk("in_ready_blocked", saw_block, 1);
        @(negedge clk);
        chk("after_done_pulse", done, 0);
        chk("after_busy", busy, 0);
        chk("after_busy_b", busy_b, 0);
        chk("after_count_hold", count, 64'(n_exp));
        sess_q.delete();
    endtask

    // ---------------- main test ----------------
    initial begin
        tbl[0] = mk(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1, 32'h00221820);
        tbl[1] = mk(2'd1, 6'h0F, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h1234, 26'h0, 1'b0, 32'h3C011234);
        tbl[2] = mk(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h10, 1'b0, 32'h0C000010);
        tbl[3] = mk(2'd0, 6'h00, 5'd0, 5'd5, 5'd4, 5'd2, 6'h03, 16'h0, 26'h0, 1'b1, 32'h00052083);
        tbl[4] = mk(2'd0, 6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22, 16'h0, 26'h0, 1'b0, 32'h00853022);
        tbl[5] = mk(2'd3, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h0);
        tbl[6] = mk(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0, 1'b1, 32'h2022FFFF);
        tbl[7] = mk(2'd2, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h0BFFFFFF);
        tbl[8] = mk(2'd1, 6'h23, 5'd29, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0004, 26'h3FFFFFF, 1'b1, 32'h8FA80004);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_err_fmt", err_fmt, 0);
        chk("rst_err_wrap", err_wrap, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_addr_b", mem_addr_b, 3);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;

        // Single R bundle, cycle by cycle: latency, done pulse, count
        mem_ack = 1'b1;
        start_pulse();
        chk("lat_ready", in_ready, 1);
        set_fields(tbl[0]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("lat_n_we", mem_we, 0);
        chk("lat_drain_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("lat_n1_we", mem_we, 1);
        chk("lat_n1_addr", mem_addr, 0);
        chk("lat_n1_data", mem_wdata, tbl[0].exp_word);
        @(posedge clk); #1;
        chk("lat_n2_we", mem_we, 0);
        chk("lat_n2_count", count, 1);
        @(posedge clk); #1;
        chk("lat_done", done, 1);
        chk("lat_done_busy", busy, 1);
        @(posedge clk); #1;
        chk("lat_idle_done", done, 0);
        chk("lat_idle_busy", busy, 0);
        chk("lat_idle_count", count, 1);

        // Table-driven sessions: mixed formats, illegal in the middle, wrap
        ack_mode = 0;
        for (int i = 1; i <= 3; i++) sess_q.push_back(tbl[i]);
        run_session(1'b0);
        for (int i = 4; i <= 6; i++) sess_q.push_back(tbl[i]);
        run_session(1'b0);
        ack_mode = 1;
        for (int i = 7; i <= 8; i++) sess_q.push_back(tbl[i]);
        run_session(1'b0);

        // Back-pressure: memory stalls while 6 bundles stream in
        ack_mode = 2;
        for (int i = 0; i < 6; i++) sess_q.push_back(rand_vec(1'b0, i == 5));
        run_session(1'b1);

        // Reset with a write pending and words buffered
        mem_ack = 1'b0;
        start_pulse();
        for (int i = 0; i < 3; i++) send(rand_vec(1'b0, 1'b0));
        begin
            bit seen_we;
            seen_we = 1'b0;
            for (int k = 0; k < 20 && !seen_we; k++) begin
                @(negedge clk);
                seen_we = mem_we;
            end
            if (!seen_we) fail_now("pre_reset_we");
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_addr_b", mem_addr_b, 3);
        chk("mid_rst_we_b", mem_we_b, 0);
        chk("mid_rst_ready_b", in_ready_b, 0);
        rst_n = 1'b1;
        ack_mode = 0;
        sess_q.push_back(rand_vec(1'b0, 1'b1));
        run_session(1'b0);

        // Random sessions against the model
        ack_mode = 1;
        gap_en = 1'b1;
        for (int s = 0; s < 10; s++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) sess_q.push_back(rand_vec(1'b1, i == n - 1));
            run_session(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart to the instruction decoder/control unit of the single-cycle CPU.
- Accepts decoded instruction fields (op, rs, rt, rd, shamt, func, imm, target) with a format selector, and packs them into 32-bit MIPS words.
- Buffers the words in a small FIFO and writes them sequentially into instruction memory, starting at a base address.
- Used as the program loader ahead of CPU reset release, and by benches to build instruction streams.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address.
- FIFO_DEPTH, 4, number of encoded words buffered; power of 2, at least 2.
- BASE_ADDR, 0, first memory word address written after start.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a load session; honoured only in IDLE.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept the bundle this cycle.
- in_last  input  1  the bundle is the final instruction of the session.
- fmt  input  2  00 R-type, 01 I-type, 10 J-type, 11 illegal.
- op  input  6  opcode.
- rs, rt, rd, shamt  input  5 each  register and shift fields.
- func  input  6  R-type function code.
- imm  input  16  I-type immediate.
- target  input  26  J-type target.
- mem_we  output  1  write request to instruction memory.
- mem_addr  output  ADDR_W  write word address.
- mem_wdata  output  32  encoded instruction.
- mem_ack  input  1  memory accepted the write this cycle.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse at the end of a session.
- count  output  ADDR_W+1  words written in the current or last session.
- err_fmt  output  1  sticky: an illegal-format bundle was received.
- err_wrap  output  1  sticky: the write address wrapped past 2^ADDR_W-1.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE, FIFO emptied, all outputs 0, mem_addr=BASE_ADDR. This applies mid-session too: a pending write is abandoned and mem_we drops on the next edge.
- Encoding (combinational on the input bundle, registered into the FIFO):
  - R: {op,rs,rt,rd,shamt,func}
  - I: {op,rs,rt,imm}
  - J: {op,target}
  - Unused fields are ignored. op is never overridden.
- Illegal format (fmt=11): the bundle is accepted (handshake completes) and discarded. err_fmt is set. If in_last is set, it still ends the session.
- Input handshake: a bundle transfers when in_valid && in_ready. in_ready = (state==LOAD) && !fifo_full. A full FIFO blocks push even if a pop happens in the same cycle.
- FSM:
  - IDLE: start=1 → LOAD. On entry, mem_addr=BASE_ADDR, count=0, err_fmt=0, err_wrap=0. start is ignored in every other state.
  - LOAD: accepts bundles. Transfer with in_last=1 → DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty and no write is pending → DONE.
  - DONE: done=1 for exactly one cycle → IDLE. count, err_fmt and err_wrap hold until the next start.
- Write side (active in LOAD and DRAIN):
  - When no write is pending and the FIFO is non-empty, pop the head. Next cycle: mem_we=1, mem_wdata=word, mem_addr=current address.
  - mem_we, mem_addr and mem_wdata hold stable until mem_ack=1.
  - On ack: mem_we drops next cycle unless another word is popped back-to-back, giving a sustained rate of 1 word/cycle when mem_ack is tied high.
  - On ack: mem_addr increments and count increments.
  - mem_ack while mem_we=0 is ignored.
- Latency: a bundle accepted at edge N into an empty FIFO, with no write pending, gives mem_we=1 after edge N+1.
- Address wrap: an increment from 2^ADDR_W-1 yields 0 and sets err_wrap. Writing continues.
- Ordering: words are written in acceptance order, with no gaps or duplicates. Illegal bundles consume no address.

Test Plan:
- Reset, start, then single R bundle (op=0, rs=1, rt=2, rd=3, shamt=0, func=0x20, in_last=1), mem_ack tied 1 → one write: addr 0, data 0x00221820. Then done pulse, count=1, busy=0.
- Three bundles back-to-back with mem_ack=1:
  - I: op=0x0F, rt=1, imm=0x1234
  - J: op=0x03, target=0x10
  - R: sra, func=0x03, rd=4, rt=5, shamt=2, in_last=1
  - Required writes: addr 0/1/2 with data 0x3C011234, 0x0C000010, 0x00052083. count=3.
- Hold mem_ack=0 and stream 6 bundles → in_ready drops after the FIFO fills. Release mem_ack → all 6 words written in order, no loss.
- Bundle with fmt=11 between two legal bundles → err_fmt=1, only 2 writes at consecutive addresses, count=2.
- ADDR_W=2, BASE_ADDR=3, two bundles → writes at addr 3 then 0, err_wrap=1.
- Assert rst_n=0 while mem_we=1 and mem_ack=0 → next edge: mem_we=0, busy=0, FIFO empty. A fresh start then writes from BASE_ADDR.
